// File: rtl/ncc_peak_finder.sv
// ncc_peak_finder: scans one search window of raster-ordered signed 8-bit NCC
// scores and reports the best score, its (x, y) offset and the second-best
// score through a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             pulse; begins (or restarts) a search window
//   threshold         signed acceptance threshold, sampled on start
//   in_valid/in_ready score stream handshake (in_ready high only while scanning)
//   in_score          signed correlation score
//   out_valid/out_ready result record handshake
//   out_best_score, out_best_x, out_best_y, out_second_score, out_found
//   busy              block is not idle
module ncc_peak_finder #(
   parameter int unsigned WIN_W = 25,
   parameter int unsigned WIN_H = 25,
   parameter int unsigned XW    = (WIN_W > 1) ? $clog2(WIN_W) : 1,
   parameter int unsigned YW    = (WIN_H > 1) ? $clog2(WIN_H) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic signed [7:0] threshold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_score,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] out_best_score,
   output logic [XW-1:0]     out_best_x,
   output logic [YW-1:0]     out_best_y,
   output logic signed [7:0] out_second_score,
   output logic              out_found,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StScan, StReport} state_t;

   localparam logic signed [7:0] MinScore = 8'sh80;

   state_t            state;
   logic signed [7:0] best, second, thr;
   logic [XW-1:0]     x, best_x;
   logic [YW-1:0]     y, best_y;
   logic              found, valid_r;

   logic              xfer, last_x, last;
   logic signed [7:0] best_n, second_n;
   logic [XW-1:0]     best_x_n;
   logic [YW-1:0]     best_y_n;

   always_comb begin
      in_ready = (state == StScan);
      busy     = (state != StIdle);
      // A start in SCAN discards any transfer in the same cycle.
      xfer     = in_valid && in_ready && !start;
      last_x   = (x == XW'(WIN_W - 1));
      last     = last_x && (y == YW'(WIN_H - 1));

      best_n   = best;
      second_n = second;
      best_x_n = best_x;
      best_y_n = best_y;
      // Strict '>' keeps the first occurrence of the maximum; a tie with best
      // still lands in second.
      if (in_score > best) begin
         second_n = best;
         best_n   = in_score;
         best_x_n = x;
         best_y_n = y;
      end else if (in_score > second) begin
         second_n = in_score;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         best    <= MinScore;
         second  <= MinScore;
         thr     <= '0;
         x       <= '0;
         y       <= '0;
         best_x  <= '0;
         best_y  <= '0;
         found   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StScan: begin
               if (start) begin
                  thr    <= threshold;
                  best   <= MinScore;
                  second <= MinScore;
                  x      <= '0;
                  y      <= '0;
                  best_x <= '0;
                  best_y <= '0;
                  state  <= StScan;
               end else if (xfer) begin
                  best   <= best_n;
                  second <= second_n;
                  best_x <= best_x_n;
                  best_y <= best_y_n;
                  if (last_x) begin
                     x <= '0;
                     y <= last ? '0 : y + YW'(1);
                  end else begin
                     x <= x + XW'(1);
                  end
                  if (last) begin
                     found   <= (best_n >= thr);
                     valid_r <= 1'b1;
                     state   <= StReport;
                  end
               end
            end
            StReport: begin
               if (out_ready) begin
                  valid_r <= 1'b0;
                  state   <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // best/second/position only change in IDLE/SCAN, so they are stable in REPORT.
   assign out_valid        = valid_r;
   assign out_best_score   = best;
   assign out_best_x       = best_x;
   assign out_best_y       = best_y;
   assign out_second_score = second;
   assign out_found        = found;

endmodule

// File: tb/tb_ncc_peak_finder.sv
module tb_ncc_peak_finder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, start, start_d, in_valid, out_ready;
   logic signed [7:0] threshold, in_score;

   // Small 4x3 instance
   logic              in_ready, out_valid, out_found, busy;
   logic signed [7:0] best, second;
   logic [1:0]        bx, by;

   // Default 25x25 instance
   logic              in_ready_d, out_valid_d, out_found_d, busy_d;
   logic signed [7:0] best_d, second_d;
   logic [4:0]        bx_d, by_d;

   ncc_peak_finder #(.WIN_W(4), .WIN_H(3)) dut (
      .clk(clk), .rst(rst), .start(start), .threshold(threshold),
      .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_best_score(best), .out_best_x(bx), .out_best_y(by),
      .out_second_score(second), .out_found(out_found), .busy(busy)
   );

   ncc_peak_finder dut_d (
      .clk(clk), .rst(rst), .start(start_d), .threshold(threshold),
      .in_valid(in_valid), .in_ready(in_ready_d), .in_score(in_score),
      .out_valid(out_valid_d), .out_ready(out_ready),
      .out_best_score(best_d), .out_best_x(bx_d), .out_best_y(by_d),
      .out_second_score(second_d), .out_found(out_found_d), .busy(busy_d)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int xfers    = 0;
   int xfers_d  = 0;
   logic signed [7:0] sc [625];

   always @(posedge clk) begin
      if (in_valid && in_ready)   xfers++;
      if (in_valid && in_ready_d) xfers_d++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
   endtask

   task automatic begin_win(input int thr, input bit sel);
      threshold = 8'(thr);
      if (sel) start_d = 1'b1;
      else     start   = 1'b1;
      tick();
      start   = 1'b0;
      start_d = 1'b0;
   endtask

   task automatic feed(input int n, input bit gaps, input bit sel);
      int sent = 0;
      int cyc  = 0;
      bit rdy;
      while (sent < n && cyc < 5000) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_score = sc[sent];
         rdy = sel ? in_ready_d : in_ready;
         if (in_valid && rdy) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      if (sent != n) check_eq("feed_budget", 32'(sent), 32'(n));
   endtask

   task automatic check_res(input string t, input int b, input int x, input int y,
                            input int s, input int f);
      check_eq({t, "_valid"},  32'(out_valid), 1);
      check_eq({t, "_best"},   32'(best), 32'(b));
      check_eq({t, "_x"},      32'(bx), 32'(x));
      check_eq({t, "_y"},      32'(by), 32'(y));
      check_eq({t, "_second"}, 32'(second), 32'(s));
      check_eq({t, "_found"},  32'(out_found), 32'(f));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   int exp_second;

   initial begin
      rst = 1'b1; start = 1'b0; start_d = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      threshold = '0; in_score = '0;
      tick(); tick();
      check_eq("rst_in_ready", 32'(in_ready), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_best", 32'(best), -128);
      check_eq("rst_second", 32'(second), -128);
      check_eq("rst_bx", 32'(bx), 0);
      check_eq("rst_found", 32'(out_found), 0);
      rst = 1'b0;
      tick();
      check_eq("idle_in_ready", 32'(in_ready), 0);

      // Ramp 0..11, result exactly one cycle after the 12th transfer
      begin_win(0, 0);
      check_eq("scan_in_ready", 32'(in_ready), 1);
      check_eq("scan_busy", 32'(busy), 1);
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_score = 8'(i);
         if (i == 11) check_eq("ramp_early_valid", 32'(out_valid), 0);
         tick();
      end
      in_valid = 1'b0;
      check_res("ramp", 11, 3, 2, 10, 1);
      handshake();
      check_eq("ramp_done_valid", 32'(out_valid), 0);
      check_eq("ramp_done_busy", 32'(busy), 0);

      // Ties and negatives
      for (int i = 0; i < 12; i++) sc[i] = -8'sd20;
      sc[1] = 8'sd7; sc[10] = 8'sd7;
      begin_win(-5, 0);
      feed(12, 0, 0);
      check_res("tie", 7, 1, 0, 7, 1);
      handshake();
      sc[1] = -8'sd6; sc[10] = -8'sd6;
      begin_win(-5, 0);
      feed(12, 0, 0);
      check_res("tie_neg", -6, 1, 0, -6, 0);
      handshake();

      // Backpressure with input gaps; threshold equals the peak
      sc[0] = -25; sc[1] = 12;  sc[2] = -1; sc[3] = -14;
      sc[4] = 23;  sc[5] = 10;  sc[6] = -3; sc[7] = -16;
      sc[8] = 21;  sc[9] = 8;   sc[10] = -5; sc[11] = -18;
      xfers = 0;
      begin_win(23, 0);
      feed(12, 1, 0);
      check_res("bp", 23, 0, 1, 21, 1);
      for (int k = 0; k < 5; k++) begin
         check_eq("stall_valid", 32'(out_valid), 1);
         check_eq("stall_in_ready", 32'(in_ready), 0);
         check_eq("stall_best", 32'(best), 23);
         check_eq("stall_x", 32'(bx), 0);
         check_eq("stall_y", 32'(by), 1);
         start = (k == 2);
         tick();
         start = 1'b0;
      end
      check_res("bp_held", 23, 0, 1, 21, 1);
      check_eq("bp_xfers", 32'(xfers), 12);
      check_eq("bp_busy_before", 32'(busy), 1);
      handshake();
      check_eq("bp_busy_after", 32'(busy), 0);
      check_eq("bp_valid_after", 32'(out_valid), 0);

      // Abort: a start mid-window (with a colliding transfer) restarts it
      sc[0] = 3; sc[1] = 100; sc[2] = 5; sc[3] = 6; sc[4] = 7;
      begin_win(0, 0);
      feed(5, 0, 0);
      in_valid = 1'b1; in_score = 8'sd100; start = 1'b1;
      tick();
      in_valid = 1'b0; start = 1'b0;
      check_eq("abort_in_ready", 32'(in_ready), 1);
      check_eq("abort_best_reinit", 32'(best), -128);
      for (int i = 0; i < 12; i++) sc[i] = -8'sd1;
      feed(12, 0, 0);
      check_res("abort", -1, 0, 0, -1, 0);
      handshake();

      // Asynchronous reset mid-scan
      for (int i = 0; i < 12; i++) sc[i] = 8'(i);
      begin_win(0, 0);
      feed(6, 0, 0);
      #1 rst = 1'b1;
      #1;
      check_eq("arst_in_ready", 32'(in_ready), 0);
      check_eq("arst_busy", 32'(busy), 0);
      check_eq("arst_valid", 32'(out_valid), 0);
      check_eq("arst_best", 32'(best), -128);
      #1 rst = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) sc[i] = 8'(11 - i);
      begin_win(20, 0);
      feed(12, 0, 0);
      check_res("post_rst", 11, 0, 0, 10, 0);
      handshake();

      // Default 25x25: unique max 127 at the last offset
      exp_second = -128;
      for (int i = 0; i < 624; i++) begin
         sc[i] = 8'(int'($urandom_range(0, 254)) - 128);
         if (int'(sc[i]) > exp_second) exp_second = int'(sc[i]);
      end
      sc[624] = 8'sd127;
      xfers_d = 0;
      begin_win(0, 1);
      feed(625, 0, 1);
      check_eq("def_valid", 32'(out_valid_d), 1);
      check_eq("def_best", 32'(best_d), 127);
      check_eq("def_x", 32'(bx_d), 24);
      check_eq("def_y", 32'(by_d), 24);
      check_eq("def_second", 32'(second_d), 32'(exp_second));
      check_eq("def_found", 32'(out_found_d), 1);
      in_valid = 1'b1; in_score = 8'sd5;
      check_eq("def_626_ready", 32'(in_ready_d), 0);
      tick();
      in_valid = 1'b0;
      check_eq("def_xfers", 32'(xfers_d), 625);
      handshake();
      check_eq("def_done_valid", 32'(out_valid_d), 0);
      check_eq("def_done_busy", 32'(busy_d), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ncc_peak_finder.md
Name: ncc_peak_finder

Overview:
- Consumes the raster-ordered stream of 8-bit correlation scores produced by the NCC processing-element chain: one score per candidate offset of the descriptor inside the search window.
- Tracks the best score, the second-best score and the (x, y) offset of the best score over one search window.
- Presents a single result record to the downstream feature-matching logic with a valid/ready handshake.

Parameters:
- WIN_W, 25, candidate offsets per row of the search window (>=1).
- WIN_H, 25, candidate rows per search window (>=1).
- XW, $clog2(WIN_W) (min 1), width of the x offset.
- YW, $clog2(WIN_H) (min 1), width of the y offset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a new search window.
- threshold  in  8  signed two's-complement acceptance threshold; sampled on start.
- in_valid  in  1  in_score is valid.
- in_ready  out  1  block accepts a score this cycle.
- in_score  in  8  signed two's-complement correlation score.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record.
- out_best_score  out  8  signed maximum score.
- out_best_x  out  XW  column of the maximum.
- out_best_y  out  YW  row of the maximum.
- out_second_score  out  8  signed second-highest score.
- out_found  out  1  out_best_score >= the latched threshold (signed compare).
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, SCAN, REPORT.
- Reset:
  - state=IDLE, in_ready=0, out_valid=0, busy=0.
  - best=second=8'h80 (-128); x=y=0; best_x=best_y=0; out_found=0; latched threshold=0.
- IDLE:
  - start=1: latch threshold; best=second=-128; x=y=0; best_x=best_y=0; go to SCAN next cycle.
  - Scores are not accepted in IDLE; in_ready=0.
- SCAN:
  - in_ready=1 (combinational from state only).
  - A transfer is in_valid&&in_ready at a rising edge.
  - Per transfer, with s=in_score and signed compares:
    - s>best: second<=best; best<=s; best_x<=x; best_y<=y.
    - else s>second: second<=s.
    - Ties with best do not move the position (first occurrence wins). A tie with best does update second, so second==best.
  - Position counters: x increments per transfer. At x==WIN_W-1, x wraps to 0 and y increments.
  - Transfer at x==WIN_W-1 and y==WIN_H-1 (the WIN_W*WIN_H-th sample): that sample is included in the result, and state goes to REPORT next cycle.
  - start=1 in SCAN aborts the window. It reinitialises exactly as from IDLE and stays in SCAN. A transfer in the same cycle is discarded.
- REPORT:
  - out_valid=1; in_ready=0.
  - All out_* fields are registered, held stable until the handshake, and unchanged by start.
  - out_found = (best >= latched threshold), registered on entry.
  - out_valid&&out_ready: go to IDLE next cycle and drop out_valid.
  - start during REPORT is ignored. A start in the same cycle as the accepting handshake is also ignored; upstream issues start only when busy=0.
- Outputs after handshake: out_* keep their last values while out_valid=0; they are don't-care.
- Latency: the result is visible the cycle after the final transfer. Minimum window time is WIN_W*WIN_H+2 cycles including start and handshake.
- An asynchronous rst mid-SCAN or mid-REPORT returns immediately to the reset values. Any partial result is lost.

Test Plan:
- Ramp, WIN_W=4, WIN_H=3, threshold=0: scores 0..11 raster with in_valid held high -> out_valid exactly one cycle after the 12th transfer; best=11, x=3, y=2, second=10, found=1.
- Ties and negatives, WIN_W=4, WIN_H=3, threshold=-5: all scores -20 except 7 at (1,0) and 7 at (2,2) -> best=7, x=1, y=0, second=7, found=1. Repeat with peak=-6 -> found=0.
- Backpressure and gaps: random in_valid gaps; out_ready held low 5 cycles after out_valid -> outputs stable through the stall, in_ready=0 in REPORT, exactly 12 transfers counted, busy falls one cycle after the handshake.
- Abort: start, 5 transfers including 100 at (1,0), then start again, then 12 scores all -1 -> best=-1, x=0, y=0, second=-1; the 100 does not appear.
- Reset mid-SCAN: assert rst after 6 transfers -> in_ready=0, busy=0, out_valid=0 immediately. A following full window reports correct results.
- Default params: 625 random scores with a unique max of 127 at (24,24) -> best_x=24, best_y=24. The 626th in_valid sample is not accepted (in_ready=0).
